spi_reg_ctrl: RTL and testbench

- Transaction sequencer behind the byte-level SPI slave. Turns the slave's per-byte strobe and received bytes into framed register accesses on a simple req/ack register bus.
- Frame format: byte 0 = command {rw, addr[6:0]}, then data bytes. Supplies each outgoing byte to the slave early enough for the slave's load point.
- Sits between the SPI slave and the FPGA register file (motor, kicker and status registers).

---
 rtl/spi_reg_pkg.sv | 39 +++
 rtl/spi_reg_timeout.sv | 44 ++++
 rtl/spi_reg_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_reg_pkg
//  Purpose  : Shared definitions for the SPI register-access sequencer:
//             FSM state encoding, fixed response bytes, command-byte field
//             positions and the default device identifier.
//  Revision : 1.0  initial release
// ============================================================================
package spi_reg_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_HOLD = 3'd3,
        S_WR_DATA = 3'd4,
        S_WR_REQ  = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    // Byte shifted out while no read data is available / after an abort
    localparam logic [7:0] FILLER = 8'h00;
    localparam logic [7:0] ABORT  = 8'hFF;

    // Command byte layout: {rw, addr[6:0]}, rw=1 means read
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;
    localparam int CMD_ADDR_LSB = 0;

    localparam logic [6:0] DEV_ID_DEFAULT = 7'h2A;

    // Status byte returned as byte 0 of every frame
    function automatic logic [7:0] status_byte(input logic err, input logic [6:0] dev_id);
        return {err, dev_id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_reg_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_reg_timeout
//  Purpose  : Cycle counter that flags an expired register access.
//             o_expired is high in the ACK_TIMEOUT-th consecutive enabled
//             cycle, so a strobe acted on at that edge is high for exactly
//             ACK_TIMEOUT cycles.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             i_clear       - synchronous counter clear (has priority)
//             i_enable      - count this cycle
//             o_expired     - limit reached in this enabled cycle
//  Revision : 1.0  initial release
// ============================================================================
module spi_reg_timeout #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Saturates at the limit; the sequencer always leaves the access then
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_reg_ctrl
//  Purpose  : Frames the byte stream of an SPI slave into register-bus
//             accesses. Byte 0 of a frame is the command {rw, addr[6:0]};
//             following bytes are write data or clocked-out read data.
//             Reads are prefetched so data starts at frame byte 2.
//  Ports    : clk, rst                 - clock, async active-high reset
//             i_ssel_active            - chip select asserted (synchronised)
//             i_byte_done / i_byte_in  - per-byte strobe and received byte
//             o_byte_out               - next byte for the slave to send
//             o_reg_addr/o_reg_wdata   - register address / write data
//             o_reg_we / o_reg_re      - held requests until ack or abort
//             i_reg_ack / i_reg_rdata  - completion strobe and read data
//             o_busy                   - not in IDLE
//             o_err                    - sticky timeout/abort flag
//  Config   : SPI_REG_CTRL_AUTOINC_EN - when defined, the address advances
//             after every access (7-bit wrap); otherwise it is fixed for
//             the whole frame.
//  Revision : 1.0  initial release
// ============================================================================
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 16,
    parameter logic [6:0] DEV_ID      = DEV_ID_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ssel_active,
    input  logic       i_byte_done,
    input  logic [7:0] i_byte_in,
    output logic [7:0] o_byte_out,
    output logic [6:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic       i_reg_ack,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic       o_err
);

    state_t     r_state;
    logic [7:0] r_byte_out;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rbuf;
    logic       r_we;
    logic       r_re;
    logic       r_err;

    state_t     w_state_nxt;
    logic [7:0] w_byte_out_nxt;
    logic [6:0] w_addr_nxt;
    logic [7:0] w_wdata_nxt;
    logic [7:0] w_rbuf_nxt;
    logic       w_we_nxt;
    logic       w_re_nxt;
    logic       w_err_nxt;

    logic       w_strobe;
    logic       w_ack;
    logic       w_expired;
    logic [6:0] w_addr_inc;
    logic [7:0] w_status;

    // Strobes are gated by chip select so a dropped frame releases the bus
    // in the same cycle, before the state register catches up.
    assign o_reg_we    = r_we && i_ssel_active;
    assign o_reg_re    = r_re && i_ssel_active;
    assign o_reg_addr  = r_addr;
    assign o_reg_wdata = r_wdata;
    assign o_byte_out  = r_byte_out;
    assign o_busy      = (r_state != S_IDLE);
    assign o_err       = r_err;

    assign w_strobe = o_reg_we || o_reg_re;
    assign w_ack    = i_reg_ack && (r_we || r_re);
    assign w_status = status_byte(r_err, DEV_ID);

`ifdef SPI_REG_CTRL_AUTOINC_EN
    assign w_addr_inc = r_addr + 7'd1;
`else
    assign w_addr_inc = r_addr;
`endif

    spi_reg_timeout #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_strobe || i_reg_ack),
        .i_enable  (w_strobe),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte_out <= status_byte(1'b0, DEV_ID);
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rbuf     <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_out <= w_byte_out_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rbuf     <= w_rbuf_nxt;
            r_we       <= w_we_nxt;
            r_re       <= w_re_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_out_nxt = r_byte_out;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_rbuf_nxt     = r_rbuf;
        w_we_nxt       = r_we;
        w_re_nxt       = r_re;
        w_err_nxt      = r_err;

        if (!i_ssel_active) begin
            // Between frames: keep the status byte preloaded for byte 0
            w_state_nxt    = S_IDLE;
            w_we_nxt       = 1'b0;
            w_re_nxt       = 1'b0;
            w_byte_out_nxt = w_status;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_CMD;
                end

                S_CMD: begin
                    if (i_byte_done) begin
                        // Status has just been shifted out, so err is reported
                        w_err_nxt      = 1'b0;
                        w_addr_nxt     = i_byte_in[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        w_byte_out_nxt = FILLER;
                        if (i_byte_in[CMD_RW_BIT]) begin
                            w_re_nxt    = 1'b1;
                            w_state_nxt = S_RD_REQ;
                        end else begin
                            w_state_nxt = S_WR_DATA;
                        end
                    end
                end

                S_RD_REQ: begin
                    // Re-arm after a back-to-back completion left a bubble
                    if (!r_re) begin
                        w_re_nxt = 1'b1;
                    end
                    if (w_ack) begin
                        w_re_nxt = 1'b0;
                        if (i_byte_done) begin
                            // Data and load point coincide: send it directly
                            // and prefetch the next register.
                            w_byte_out_nxt = i_reg_rdata;
                            w_addr_nxt     = w_addr_inc;
                        end else begin
                            w_rbuf_nxt  = i_reg_rdata;
                            w_state_nxt = S_RD_HOLD;
                        end
                    end else if (i_byte_done || w_expired) begin
                        w_re_nxt       = 1'b0;
                        w_err_nxt      = 1'b1;
                        w_byte_out_nxt = ABORT;
                        w_state_nxt    = S_DRAIN;
                    end
                end

                S_RD_HOLD: begin
                    if (i_byte_done) begin
                        w_byte_out_nxt = r_rbuf;
                        w_addr_nxt     = w_addr_inc;
                        w_re_nxt       = 1'b1;
                        w_state_nxt    = S_RD_REQ;
                    end
                end

                S_WR_DATA: begin
                    if (i_byte_done) begin
                        w_wdata_nxt = i_byte_in;
                        w_we_nxt    = 1'b1;
                        w_state_nxt = S_WR_REQ;
                    end
                end

                S_WR_REQ: begin
                    if (!r_we) begin
                        w_we_nxt = 1'b1;
                    end
                    if (w_ack) begin
                        w_we_nxt   = 1'b0;
                        w_addr_nxt = w_addr_inc;
                        if (i_byte_done) begin
                            // Next data byte arrived with the ack: queue it
                            w_wdata_nxt = i_byte_in;
                        end else begin
                            w_state_nxt = S_WR_DATA;
                        end
                    end else if (i_byte_done || w_expired) begin
                        w_we_nxt       = 1'b0;
                        w_err_nxt      = 1'b1;
                        w_byte_out_nxt = ABORT;
                        w_state_nxt    = S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    w_byte_out_nxt = ABORT;
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_we_nxt    = 1'b0;
                    w_re_nxt    = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_ctrl
//  Purpose  : Self-checking bench for spi_reg_ctrl. Frame stimulus pushes the
//             expected outgoing bytes and register accesses into queues;
//             independent monitors pop and compare them.
//  Config   : SPI_REG_CTRL_AUTOINC_EN selects the expected address sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_reg_ctrl;

    localparam logic [7:0] ST_OK  = 8'h2A;  // {err=0, DEV_ID=2A}
    localparam logic [7:0] ST_ERR = 8'hAA;  // {err=1, DEV_ID=2A}
`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ssel = 1'b0;
    logic       byte_done = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic [7:0] byte_out;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic       reg_ack;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err;

    logic       resp_ack = 1'b0;
    logic [7:0] resp_rdata = 8'h00;
    logic       man_ack = 1'b0;
    logic [7:0] man_rdata = 8'h00;
    logic       ack_en = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_byte[$];
    acc_t       exp_acc[$];

    assign reg_ack   = resp_ack | man_ack;
    assign reg_rdata = man_ack ? man_rdata : resp_rdata;

    always #5 clk = ~clk;

    spi_reg_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_ssel_active (ssel),
        .i_byte_done   (byte_done),
        .i_byte_in     (byte_in),
        .o_byte_out    (byte_out),
        .o_reg_addr    (reg_addr),
        .o_reg_wdata   (reg_wdata),
        .o_reg_we      (reg_we),
        .o_reg_re      (reg_re),
        .i_reg_ack     (reg_ack),
        .i_reg_rdata   (reg_rdata),
        .o_busy        (busy),
        .o_err         (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_byte(input string name);
        logic [7:0] e;
        if (exp_byte.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got 0x%02h, no byte expected", name, byte_out);
        end else begin
            e = exp_byte.pop_front();
            check(name, {24'h0, byte_out}, {24'h0, e});
        end
    endtask

    function automatic logic [6:0] nxt(input logic [6:0] a);
        return AUTOINC ? a + 7'd1 : a;
    endfunction

    function automatic acc_t mk(input logic we, input logic [6:0] a, input logic [7:0] d);
        acc_t r;
        r.we = we; r.addr = a; r.wdata = d;
        return r;
    endfunction

    // Register file model: acks 3 cycles after a request is seen
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ack_en && (reg_re || reg_we)) begin
                repeat (2) begin @(posedge clk); #1; end
                resp_rdata = {1'b0, reg_addr} + 8'h40;
                resp_ack   = 1'b1;
                @(posedge clk); #1;
                resp_ack   = 1'b0;
            end
        end
    end

    // Outgoing-byte monitor: status at frame start, then the byte the slave
    // samples two cycles after each byte_done
    initial begin
        logic prev_ssel;
        prev_ssel = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                if (ssel && !prev_ssel) pop_byte("status_byte");
                prev_ssel = ssel;
                if (byte_done) begin
                    @(posedge clk);
                    @(posedge clk); #1;
                    pop_byte("byte_out");
                end
            end else begin
                prev_ssel = 1'b0;
            end
        end
    end

    // Access monitor: every completed register access
    initial begin
        acc_t e;
        forever begin
            @(negedge clk);
            if (reg_ack && (reg_re || reg_we)) begin
                if (exp_acc.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_access: got we=%0d addr=0x%02h", reg_we, reg_addr);
                end else begin
                    e = exp_acc.pop_front();
                    check("acc_we", {31'h0, reg_we}, {31'h0, e.we});
                    check("acc_addr", {25'h0, reg_addr}, {25'h0, e.addr});
                    if (e.we) check("acc_wdata", {24'h0, reg_wdata}, {24'h0, e.wdata});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start(input logic [7:0] st);
        exp_byte.push_back(st);
        @(negedge clk);
        ssel = 1'b1;
        tick(2);
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] next_out, input int gap);
        exp_byte.push_back(next_out);
        @(negedge clk);
        byte_in   = b;
        byte_done = 1'b1;
        @(negedge clk);
        byte_done = 1'b0;
        tick(gap);
    endtask

    task automatic frame_end();
        @(negedge clk);
        ssel = 1'b0;
        tick(3);
    endtask

    initial begin
        int cnt;
        logic [6:0] a;

        // Reset values
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_byte_out", {24'h0, byte_out}, {24'h0, ST_OK});
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_we", {31'h0, reg_we}, 32'h0);
        check("rst_re", {31'h0, reg_re}, 32'h0);
        check("rst_addr", {25'h0, reg_addr}, 32'h0);

        // Chip select with no bytes
        frame_start(ST_OK);
        check("idle_frame_busy", {31'h0, busy}, 32'h1);
        check("idle_frame_strobes", {31'h0, reg_we | reg_re}, 32'h0);
        frame_end();

        // Write frame 0x05, 0x11, 0x22
        frame_start(ST_OK);
        send(8'h05, 8'h00, 10);
        exp_acc.push_back(mk(1'b1, 7'h05, 8'h11));
        send(8'h11, 8'h00, 10);
        exp_acc.push_back(mk(1'b1, nxt(7'h05), 8'h22));
        send(8'h22, 8'h00, 10);
        frame_end();

        // Read frame 0x83 + filler, rdata = addr + 0x40
        frame_start(ST_OK);
        a = 7'h03;
        exp_acc.push_back(mk(1'b0, a, 8'h00));
        send(8'h83, 8'h00, 10);
        exp_acc.push_back(mk(1'b0, nxt(a), 8'h00));
        send(8'h00, 8'h43, 10);
        exp_acc.push_back(mk(1'b0, nxt(nxt(a)), 8'h00));
        send(8'h00, {1'b0, nxt(a)} + 8'h40, 10);
        frame_end();

        // Read wrap at 0x7F
        frame_start(ST_OK);
        exp_acc.push_back(mk(1'b0, 7'h7F, 8'h00));
        send(8'hFF, 8'h00, 10);
        exp_acc.push_back(mk(1'b0, nxt(7'h7F), 8'h00));
        send(8'h00, 8'hBF, 10);
        frame_end();

        // Write without ack: timeout
        ack_en = 1'b0;
        frame_start(ST_OK);
        send(8'h10, 8'h00, 2);
        send(8'h55, 8'h00, 0);
        check("to_we_high", {31'h0, reg_we}, 32'h1);
        cnt = 0;
        while (reg_we && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("to_we_cycles", cnt, 16);
        check("to_byte_out", {24'h0, byte_out}, 32'hFF);
        check("to_err", {31'h0, err}, 32'h1);
        check("to_busy", {31'h0, busy}, 32'h1);
        tick(3);
        check("drain_byte_out", {24'h0, byte_out}, 32'hFF);
        ack_en = 1'b1;
        frame_end();

        // Error reported in the next status byte, then cleared
        frame_start(ST_ERR);
        check("err_before_cmd", {31'h0, err}, 32'h1);
        send(8'h01, 8'h00, 3);
        check("err_cleared", {31'h0, err}, 32'h0);
        frame_end();
        frame_start(ST_OK);
        frame_end();

        // Chip select dropped during a pending read
        ack_en = 1'b0;
        frame_start(ST_OK);
        send(8'h84, 8'h00, 2);
        check("drop_re_before", {31'h0, reg_re}, 32'h1);
        @(negedge clk);
        ssel = 1'b0;
        #1;
        check("drop_re_same_clk", {31'h0, reg_re}, 32'h0);
        @(posedge clk); #1;
        check("drop_busy", {31'h0, busy}, 32'h0);
        check("drop_byte_out", {24'h0, byte_out}, {24'h0, ST_OK});
        @(negedge clk);
        man_rdata = 8'h77;
        man_ack   = 1'b1;
        @(negedge clk);
        man_ack   = 1'b0;
        tick(1);
        check("late_ack_re", {31'h0, reg_re}, 32'h0);
        check("late_ack_busy", {31'h0, busy}, 32'h0);
        check("late_ack_byte_out", {24'h0, byte_out}, {24'h0, ST_OK});
        check("late_ack_err", {31'h0, err}, 32'h0);
        ack_en = 1'b1;
        tick(2);

        // Asynchronous reset during a pending write
        ack_en = 1'b0;
        frame_start(ST_OK);
        send(8'h07, 8'h00, 2);
        send(8'h99, 8'h00, 3);
        check("mid_we", {31'h0, reg_we}, 32'h1);
        check("mid_addr", {25'h0, reg_addr}, 32'h07);
        check("mid_wdata", {24'h0, reg_wdata}, 32'h99);
        #2;
        rst = 1'b1;
        #1;
        check("arst_we", {31'h0, reg_we}, 32'h0);
        check("arst_byte_out", {24'h0, byte_out}, {24'h0, ST_OK});
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_addr", {25'h0, reg_addr}, 32'h0);
        check("arst_wdata", {24'h0, reg_wdata}, 32'h0);
        check("arst_err", {31'h0, err}, 32'h0);
        ssel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        tick(5);

        check("pending_bytes", exp_byte.size(), 0);
        check("pending_accesses", exp_acc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
